// File: rtl/sd_dat_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sd_dat_engine
//  Purpose  : SD data-line engine. Moves one block between the SD D lines
//             and a LANES-wide RAM in read or write mode, with per-lane
//             CRC16, CRC-status token check, busy wait and timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_dat_engine #(
    parameter int LANES       = 4,
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_W      = 10,
    parameter int NAC_MAX     = 65535,
    parameter int BUSY_MAX    = 65535
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic              imode,
    input  logic [LANES-1:0]  idata_sd,
    output logic [LANES-1:0]  odata_sd,
    output logic              odata_oe,
    output logic [ADDR_W-1:0] oaddr,
    input  logic [LANES-1:0]  irdata,
    output logic [LANES-1:0]  owdata,
    output logic              owrite_en,
    output logic              ocrc_fail,
    output logic              otimeout,
    output logic              obusy,
    output logic              odone
);
    localparam int DEPTH   = BLOCK_BYTES * 8 / LANES;
    localparam int MAX_A   = (DEPTH > NAC_MAX) ? DEPTH : NAC_MAX;
    localparam int MAX_B   = (MAX_A > BUSY_MAX) ? MAX_A : BUSY_MAX;
    localparam int CNT_LIM = (MAX_B > 16) ? MAX_B : 16;
    localparam int CNT_W   = $clog2(CNT_LIM + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] NAC_LAST  = CNT_W'(NAC_MAX - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_MAX - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(15);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] TOK_END   = CNT_W'(3);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_R_WAIT  = 4'd1;
    localparam logic [3:0] S_R_DATA  = 4'd2;
    localparam logic [3:0] S_R_CRC   = 4'd3;
    localparam logic [3:0] S_R_END   = 4'd4;
    localparam logic [3:0] S_W_PRE   = 4'd5;
    localparam logic [3:0] S_W_START = 4'd6;
    localparam logic [3:0] S_W_DATA  = 4'd7;
    localparam logic [3:0] S_W_CRC   = 4'd8;
    localparam logic [3:0] S_W_END   = 4'd9;
    localparam logic [3:0] S_W_STAT  = 4'd10;
    localparam logic [3:0] S_W_TOKEN = 4'd11;
    localparam logic [3:0] S_W_BUSY  = 4'd12;
    localparam logic [3:0] S_DONE    = 4'd13;

    logic [3:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [LANES-1:0][15:0] crc;
    logic [LANES-1:0]       crc_msb;
    logic                   crc_err;
    logic [2:0]             tok;
    // RAM read data delayed one cycle: address k+2 issued in write cycle k
    // returns data one cycle later and is driven on the lines the cycle after.
    logic [LANES-1:0]       wbuf;

    // One serial MSB-first step of CRC16 (x^16+x^12+x^5+1).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ (((b ^ c[15]) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    // Gather the top CRC bit of every lane (transmitted / compared next).
    always_comb begin
        crc_msb = '0;
        for (int l = 0; l < LANES; l++) crc_msb[l] = crc[l][15];
    end

    // Transfer sequencer: state, cycle counter, CRCs and sticky error flags.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            crc       <= '0;
            crc_err   <= 1'b0;
            tok       <= 3'b000;
            wbuf      <= '0;
            ocrc_fail <= 1'b0;
            otimeout  <= 1'b0;
        end else begin
            wbuf <= irdata;
            case (state)
                S_IDLE: if (istart) begin
                    ocrc_fail <= 1'b0;
                    otimeout  <= 1'b0;
                    cnt       <= '0;
                    crc       <= '0;
                    crc_err   <= 1'b0;
                    tok       <= 3'b000;
                    state     <= imode ? S_W_PRE : S_R_WAIT;
                end
                S_R_WAIT: begin
                    if (idata_sd == '0) begin
                        cnt   <= '0;
                        state <= S_R_DATA;
                    end else if (cnt == NAC_LAST) begin
                        otimeout <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_R_DATA: begin
                    for (int l = 0; l < LANES; l++) crc[l] <= crc_step(crc[l], idata_sd[l]);
                    if (cnt == DATA_LAST) begin
                        cnt   <= '0;
                        state <= S_R_CRC;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_R_CRC: begin
                    if (|(idata_sd ^ crc_msb)) crc_err <= 1'b1;
                    for (int l = 0; l < LANES; l++) crc[l] <= {crc[l][14:0], 1'b0};
                    if (cnt == CRC_LAST) begin
                        cnt   <= '0;
                        state <= S_R_END;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_R_END: begin
                    if (crc_err || (idata_sd != '1)) ocrc_fail <= 1'b1;
                    state <= S_DONE;
                end
                S_W_PRE: begin
                    if (cnt == PRE_LAST) begin
                        cnt   <= '0;
                        state <= S_W_START;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_W_START: state <= S_W_DATA;
                S_W_DATA: begin
                    for (int l = 0; l < LANES; l++) crc[l] <= crc_step(crc[l], wbuf[l]);
                    if (cnt == DATA_LAST) begin
                        cnt   <= '0;
                        state <= S_W_CRC;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_W_CRC: begin
                    for (int l = 0; l < LANES; l++) crc[l] <= {crc[l][14:0], 1'b0};
                    if (cnt == CRC_LAST) begin
                        cnt   <= '0;
                        state <= S_W_END;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_W_END: begin
                    cnt   <= '0;
                    state <= S_W_STAT;
                end
                S_W_STAT: begin
                    if (!idata_sd[0]) begin
                        cnt   <= '0;
                        state <= S_W_TOKEN;
                    end else if (cnt == STAT_LAST) begin
                        otimeout <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                // Three token bits are shifted in, the fourth cycle is the end bit.
                S_W_TOKEN: begin
                    if (cnt == TOK_END) begin
                        cnt <= '0;
                        if ((tok == 3'b010) && idata_sd[0]) begin
                            state <= S_W_BUSY;
                        end else begin
                            ocrc_fail <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else begin
                        tok <= {tok[1:0], idata_sd[0]};
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_W_BUSY: begin
                    if (idata_sd[0]) begin
                        state <= S_DONE;
                    end else if (cnt == BUSY_LAST) begin
                        otimeout <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line, RAM and output-enable decode from the current state.
    always_comb begin
        odata_sd  = '1;
        odata_oe  = 1'b0;
        oaddr     = '0;
        owdata    = '0;
        owrite_en = 1'b0;
        case (state)
            S_R_DATA: begin
                owdata    = idata_sd;
                owrite_en = 1'b1;
                oaddr     = ADDR_W'(cnt);
            end
            S_W_PRE: odata_oe = 1'b1;
            S_W_START: begin
                odata_oe = 1'b1;
                odata_sd = '0;
                oaddr    = ADDR_W'(1);
            end
            S_W_DATA: begin
                odata_oe = 1'b1;
                odata_sd = wbuf;
                oaddr    = ADDR_W'(cnt + CNT_TWO);
            end
            S_W_CRC: begin
                odata_oe = 1'b1;
                odata_sd = crc_msb;
            end
            S_W_END: odata_oe = 1'b1;
            default: ;
        endcase
    end

    assign obusy = (state != S_IDLE);
    assign odone = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sd_dat_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sd_dat_engine
//  Purpose  : Self-checking bench for sd_dat_engine: a 4-lane 512-byte
//             instance (reads and writes) and a 1-lane 4-byte instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_dat_engine;
    localparam int NAC  = 100;
    localparam int BSY  = 200;
    localparam int D4   = 1024;
    localparam int D1   = 32;
    localparam int MAXT = 2048;

    typedef struct packed {
        logic       we;
        logic       oe;
        logic       done;
        logic       crcf;
        logic       tmo;
        logic       busy;
        logic [9:0] addr;
        logic [3:0] wdata;
        logic [3:0] dout;
    } obs_t;

    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    logic       rst4, start4, mode4, oe4, we4, crcf4, tmo4, busy4, done4;
    logic [3:0] din4, dout4, wdata4;
    logic [3:0] rdata4 = '0;
    logic [9:0] addr4;

    logic       rst1, start1, mode1, oe1, we1, crcf1, tmo1, busy1, done1;
    logic [0:0] din1, dout1, wdata1;
    logic [0:0] rdata1 = '0;
    logic [4:0] addr1;

    logic [3:0] ram4 [D4];
    logic [0:0] ram1 [D1];
    logic [3:0] blk  [D4];
    logic [3:0] scr  [MAXT];
    logic [3:0] xs   [MAXT];

    int n_cmp = 0;
    int n_bad = 0;

    sd_dat_engine #(.LANES(4), .BLOCK_BYTES(512), .ADDR_W(10), .NAC_MAX(NAC), .BUSY_MAX(BSY)) u_dut4 (
        .iclk(iclk), .irst(rst4), .istart(start4), .imode(mode4),
        .idata_sd(din4), .odata_sd(dout4), .odata_oe(oe4), .oaddr(addr4),
        .irdata(rdata4), .owdata(wdata4), .owrite_en(we4),
        .ocrc_fail(crcf4), .otimeout(tmo4), .obusy(busy4), .odone(done4)
    );

    sd_dat_engine #(.LANES(1), .BLOCK_BYTES(4), .ADDR_W(5), .NAC_MAX(NAC), .BUSY_MAX(BSY)) u_dut1 (
        .iclk(iclk), .irst(rst1), .istart(start1), .imode(mode1),
        .idata_sd(din1), .odata_sd(dout1), .odata_oe(oe1), .oaddr(addr1),
        .irdata(rdata1), .owdata(wdata1), .owrite_en(we1),
        .ocrc_fail(crcf1), .otimeout(tmo1), .obusy(busy1), .odone(done1)
    );

    // Synchronous RAMs: data appears one cycle after the address.
    always @(posedge iclk) rdata4 <= ram4[addr4];
    always @(posedge iclk) rdata1 <= ram1[addr1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lmask(input int which);
        return (which == 0) ? 4'hF : 4'h1;
    endfunction

    // CRC16 as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] lane_crc(input int lane, input int n);
        logic [16:0] rem;
        logic        b;
        rem = '0;
        for (int i = 0; i < n + 16; i++) begin
            b   = (i < n) ? blk[i][lane] : 1'b0;
            rem = {rem[15:0], b};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic drive(input int which, input logic st, input logic md, input logic [3:0] d);
        if (which == 0) begin
            start4 = st; mode4 = md; din4 = d;
        end else begin
            start1 = st; mode1 = md; din1 = d[0:0];
        end
    endtask

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) begin
            o.we = we4; o.oe = oe4; o.done = done4; o.crcf = crcf4; o.tmo = tmo4; o.busy = busy4;
            o.addr = addr4; o.wdata = wdata4; o.dout = dout4;
        end else begin
            o.we = we1; o.oe = oe1; o.done = done1; o.crcf = crcf1; o.tmo = tmo1; o.busy = busy1;
            o.addr = {5'b0, addr1}; o.wdata = {3'b0, wdata1}; o.dout = {3'b0, dout1};
        end
        return o;
    endfunction

    // Card-side read script: w idle cycles, start bit, data, CRC, end bit.
    task automatic build_read(input int which, input int w, input bit partial,
                              input int flip_lane, input int flip_bit, input bit end_bad);
        logic [3:0]  lm;
        logic [3:0]  v;
        logic [15:0] c [4];
        int          depth;
        lm    = lmask(which);
        depth = (which == 0) ? D4 : D1;
        for (int t = 0; t < MAXT; t++) scr[t] = lm;
        for (int t = 1; t <= w && t < MAXT; t++)
            scr[t] = (partial && which == 0) ? 4'($urandom_range(1, 14)) : lm;
        for (int l = 0; l < 4; l++) c[l] = lane_crc(l, depth);
        if (w + 19 + depth < MAXT) begin
            scr[w + 1] = 4'h0;
            for (int k = 0; k < depth; k++) scr[w + 2 + k] = blk[k] & lm;
            for (int i = 0; i < 16; i++) begin
                v = 4'h0;
                for (int l = 0; l < 4; l++) v[l] = c[l][15 - i] ^ ((l == flip_lane && i == flip_bit) ? 1'b1 : 1'b0);
                scr[w + 2 + depth + i] = v & lm;
            end
            scr[w + 18 + depth] = end_bad ? (lm ^ 4'h1) : lm;
        end
    endtask

    task automatic run_read(input int which, input int w, input bit partial, input int flip_lane,
                            input int flip_bit, input bit end_bad, input int restart_at, input string nm);
        logic [3:0] lm;
        int   depth, exp_done, exp_we, n_we, bad_we, n_oe, done_t;
        bit   exp_to, exp_cf;
        obs_t o;
        lm = lmask(which);
        depth = (which == 0) ? D4 : D1;
        n_we = 0; bad_we = 0; n_oe = 0; done_t = -1;
        build_read(which, w, partial, flip_lane, flip_bit, end_bad);
        if (w >= NAC) begin
            exp_to = 1'b1; exp_cf = 1'b0; exp_done = NAC + 1; exp_we = 0;
        end else begin
            exp_to = 1'b0; exp_cf = (flip_lane >= 0) || end_bad; exp_done = w + 19 + depth; exp_we = depth;
        end
        @(posedge iclk); #1; drive(which, 1'b1, 1'b0, lm); #1;
        for (int t = 1; t < MAXT && done_t < 0; t++) begin
            @(posedge iclk); #1; drive(which, (t == restart_at), 1'b1, scr[t]); #1;
            o = sample(which);
            if (t == 1) check({nm, "_flags_clear"}, {o.busy, o.crcf, o.tmo}, 3'b100);
            if (o.we) begin
                if (n_we >= depth) bad_we++;
                else if (o.addr != 10'(n_we) || o.wdata !== (blk[n_we] & lm)) bad_we++;
                n_we++;
            end
            if (o.oe) n_oe++;
            if (o.done) begin
                done_t = t;
                check({nm, "_crc_fail"}, o.crcf, exp_cf);
                check({nm, "_timeout"}, o.tmo, exp_to);
            end
        end
        drive(which, 1'b0, 1'b0, lm);
        check({nm, "_done_cycle"}, done_t, exp_done);
        check({nm, "_write_count"}, n_we, exp_we);
        check({nm, "_write_bad"}, bad_we, 0);
        check({nm, "_oe_cycles"}, n_oe, 0);
        @(posedge iclk); #2;
        o = sample(which);
        check({nm, "_after_done"}, {o.busy, o.done, o.crcf, o.tmo}, {2'b00, exp_cf, exp_to});
    endtask

    // Write on the 4-lane instance; the card answers on lane 0 after W_END.
    task automatic run_write(input int d, input logic [2:0] tk, input bit endb, input int busy_n, input string nm);
        int          s0, t0, exp_done, nx, n_oe, bad_oe, n_we, done_t;
        bit          exp_to, exp_cf;
        logic [3:0]  v;
        logic [15:0] c [4];
        obs_t        o;
        s0 = 21 + D4; t0 = s0 + d + 1;
        nx = 0; n_oe = 0; bad_oe = 0; n_we = 0; done_t = -1;
        exp_to = 1'b0; exp_cf = 1'b0;
        for (int k = 0; k < D4; k++) ram4[k] = blk[k];
        for (int l = 0; l < 4; l++) c[l] = lane_crc(l, D4);
        xs[0] = 4'hF; xs[1] = 4'hF; xs[2] = 4'h0; nx = 3;
        for (int k = 0; k < D4; k++) begin xs[nx] = blk[k]; nx++; end
        for (int i = 0; i < 16; i++) begin
            for (int l = 0; l < 4; l++) v[l] = c[l][15 - i];
            xs[nx] = v; nx++;
        end
        xs[nx] = 4'hF; nx++;
        for (int t = 0; t < MAXT; t++) scr[t] = 4'hF;
        scr[s0 + d] = 4'hE;
        for (int i = 0; i < 3; i++) scr[s0 + d + 1 + i] = {3'b111, tk[2 - i]};
        scr[s0 + d + 4] = {3'b111, endb};
        for (int i = 0; i < busy_n; i++) if (s0 + d + 5 + i < MAXT) scr[s0 + d + 5 + i] = 4'hE;
        if (d >= 8) begin
            exp_to = 1'b1; exp_done = s0 + 8;
        end else if (tk == 3'b010 && endb) begin
            if (busy_n < BSY) exp_done = t0 + 4 + busy_n + 1;
            else begin exp_to = 1'b1; exp_done = t0 + 4 + BSY; end
        end else begin
            exp_cf = 1'b1; exp_done = t0 + 4;
        end
        @(posedge iclk); #1; drive(0, 1'b1, 1'b1, 4'hF); #1;
        for (int t = 1; t < MAXT && done_t < 0; t++) begin
            @(posedge iclk); #1; drive(0, 1'b0, 1'b1, scr[t]); #1;
            o = sample(0);
            if (t == 1) check({nm, "_flags_clear"}, {o.busy, o.crcf, o.tmo}, 3'b100);
            if (o.oe) begin
                if (t != n_oe + 1 || n_oe >= nx) bad_oe++;
                else if (o.dout !== xs[n_oe]) bad_oe++;
                n_oe++;
            end
            if (o.we) n_we++;
            if (o.done) begin
                done_t = t;
                check({nm, "_crc_fail"}, o.crcf, exp_cf);
                check({nm, "_timeout"}, o.tmo, exp_to);
            end
        end
        drive(0, 1'b0, 1'b0, 4'hF);
        check({nm, "_done_cycle"}, done_t, exp_done);
        check({nm, "_oe_cycles"}, n_oe, nx);
        check({nm, "_line_bad"}, bad_oe, 0);
        check({nm, "_ram_writes"}, n_we, 0);
        @(posedge iclk); #2;
        check({nm, "_idle_after"}, {busy4, done4}, 2'b00);
    endtask

    // Reset the 1-lane instance in the middle of R_DATA.
    task automatic reset_mid();
        obs_t o, er;
        int   saw;
        saw = 0;
        build_read(1, 3, 1'b0, -1, 0, 1'b0);
        @(posedge iclk); #1; drive(1, 1'b1, 1'b0, 4'h1); #1;
        for (int t = 1; t <= 15; t++) begin
            @(posedge iclk); #1; drive(1, 1'b0, 1'b0, scr[t]); #1;
        end
        o = sample(1);
        check("rstmid_in_rdata", {o.we, o.busy}, 2'b11);
        rst1 = 1'b0; #1;
        o = sample(1);
        er = '0; er.dout = 4'h1;
        check("rstmid_outputs", o, er);
        for (int t = 16; t < 40; t++) begin
            @(posedge iclk); #1; drive(1, 1'b0, 1'b0, scr[t]); #1;
            if (done1 !== 1'b0 || busy1 !== 1'b0 || we1 !== 1'b0) saw++;
        end
        check("rstmid_held_quiet", saw, 0);
        rst1 = 1'b1;
        drive(1, 1'b0, 1'b0, 4'h1);
        @(posedge iclk); #2;
        check("rstmid_released_idle", {busy1, done1}, 2'b00);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t o, er;
        logic [7:0] by;
        rst4 = 1'b0; rst1 = 1'b0;
        drive(0, 1'b0, 1'b0, 4'hF);
        drive(1, 1'b0, 1'b0, 4'h1);
        for (int k = 0; k < D4; k++) ram4[k] = 4'h0;
        for (int k = 0; k < D1; k++) ram1[k] = 1'b0;
        repeat (3) @(posedge iclk);
        #2;
        er = '0; er.dout = 4'hF;
        o = sample(0);
        check("reset_state_4lane", o, er);
        er.dout = 4'h1;
        o = sample(1);
        check("reset_state_1lane", o, er);
        rst4 = 1'b1; rst1 = 1'b1;
        @(posedge iclk); #2;

        for (int k = 0; k < D4; k++) blk[k] = 4'hF;
        run_read(0, 5, 1'b0, -1, 0, 1'b0, 0, "rd_ones");
        run_read(0, 5, 1'b0, 2, 7, 1'b0, 0, "rd_crcflip");
        for (int k = 0; k < D4; k++) blk[k] = 4'($urandom);
        run_read(0, int'($urandom_range(3, 20)), 1'b1, -1, 0, 1'b0, 50, "rd_rand");
        run_read(0, 2, 1'b1, -1, 0, 1'b1, 0, "rd_endbad");
        run_read(0, NAC, 1'b0, -1, 0, 1'b0, 0, "rd_nac_to");
        run_read(0, NAC - 1, 1'b0, -1, 0, 1'b0, 0, "rd_nac_edge");

        for (int k = 0; k < D4; k++) blk[k] = 4'hF;
        run_write(0, 3'b010, 1'b1, 50, "wr_ones");
        for (int k = 0; k < D4; k++) blk[k] = 4'($urandom);
        run_write(int'($urandom_range(0, 7)), 3'b010, 1'b1, int'($urandom_range(0, 30)), "wr_rand");
        run_write(2, 3'b101, 1'b1, 50, "wr_badtok");
        run_write(1, 3'b010, 1'b0, 10, "wr_badend");
        run_write(1, 3'b010, 1'b1, BSY + 10, "wr_busy_to");
        run_write(8, 3'b010, 1'b1, 5, "wr_stat_to");
        run_write(7, 3'b010, 1'b1, 0, "wr_stat_edge");

        for (int b = 0; b < 4; b++) begin
            by = 8'(b);
            for (int i = 0; i < 8; i++) blk[8 * b + i] = {3'b000, by[7 - i]};
        end
        run_read(1, 4, 1'b0, -1, 0, 1'b0, 0, "l1_bytes");
        reset_mid();
        for (int k = 0; k < D1; k++) blk[k] = {3'b000, 1'($urandom)};
        run_read(1, 3, 1'b0, 0, 3, 1'b0, 0, "l1_crcflip");
        run_read(1, 6, 1'b0, -1, 0, 1'b0, 0, "l1_rand_ok");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_dat_engine.md
Name: sd_dat_engine

Overview:
- Parametrised successor of the SD D-line driver.
- Transfers one data block over the SD bus in read or write mode, with 1 or 4 lanes (LANES).
- Adds: per-lane CRC16 generate/check, write CRC-status token check, busy wait, start-bit and busy timeouts, output-enable for the D lines.
- Sits under the sd top; clocked by clk_sd; driven by sd_fsm through istart/imode; interfaces the nibble/bit RAM.

Parameters:
LANES, 4, active D lanes (1 or 4); RAM word width = LANES.
BLOCK_BYTES, 512, bytes per block.
ADDR_W, 10, RAM address width; must satisfy 2**ADDR_W >= DEPTH, where DEPTH = BLOCK_BYTES*8/LANES.
NAC_MAX, 65535, read: max cycles waiting for the start bit.
BUSY_MAX, 65535, write: max cycles waiting for busy release.

Ports:
iclk  in  1  SD clock (clk_sd); all logic on rising edge.
irst  in  1  asynchronous active-low reset.
istart  in  1  one-cycle start pulse; accepted only in IDLE.
imode  in  1  0 = read block, 1 = write block; sampled with istart.
idata_sd  in  LANES  D lines from the card.
odata_sd  out  LANES  D lines to the card.
odata_oe  out  1  1 = engine drives the D lines.
oaddr  out  ADDR_W  RAM address.
irdata  in  LANES  RAM read data; valid one cycle after oaddr.
owdata  out  LANES  RAM write data.
owrite_en  out  1  RAM write strobe.
ocrc_fail  out  1  held at 1 from a failed transfer until the next accepted istart.
otimeout  out  1  same holding rule as ocrc_fail.
obusy  out  1  1 whenever state != IDLE.
odone  out  1  one-cycle pulse at the end of every transfer (success, CRC fail or timeout).

Behaviour:
- Reset (irst=0, asynchronous) values:
  - State IDLE; all counters and CRC registers 0.
  - odata_sd all 1; odata_oe 0; oaddr 0; owdata 0.
  - owrite_en, ocrc_fail, otimeout, obusy, odone all 0.
  - Reset mid-transfer aborts immediately; no odone pulse.
- CRC16 (each lane independent):
  - Polynomial x^16+x^12+x^5+1; initial value 0; MSB-first serial.
  - Updated on data bits only, never on start, CRC or end bits.
- istart while obusy=1 is ignored.
- Read path: IDLE -> R_WAIT -> R_DATA -> R_CRC -> R_END -> DONE.
  - R_WAIT: counter counts cycles.
    - All lanes 0 in a cycle: that is the start bit; go to R_DATA.
    - Counter reaches NAC_MAX first: set otimeout, go to DONE.
    - Only some lanes low: keep waiting.
  - R_DATA: DEPTH cycles.
    - Each cycle: owdata = idata_sd, owrite_en = 1, oaddr = k for k = 0..DEPTH-1.
    - Address wraps to 0 after the last word.
  - R_CRC: 16 cycles; received bits compared against each lane's computed CRC.
  - R_END: all lanes must be 1 (end bit).
    - Any CRC mismatch or any end bit 0: set ocrc_fail.
    - Go to DONE either way.
  - odata_oe is 0 for the whole read.
- Write path: IDLE -> W_PRE -> W_START -> W_DATA -> W_CRC -> W_END -> W_STAT -> W_BUSY -> DONE.
  - W_PRE: 2 cycles, odata_oe = 1, odata_sd all 1; oaddr = 0 during the second cycle (RAM prefetch).
  - W_START: 1 cycle, odata_sd all 0; oaddr = 1.
  - W_DATA: DEPTH cycles.
    - odata_sd = irdata; oaddr = k+2 during cycle k.
    - oaddr is don't-care for the last 2 cycles; owrite_en stays 0.
  - W_CRC: 16 cycles; each lane drives its CRC, MSB first.
  - W_END: 1 cycle, all lanes 1.
  - Then odata_oe = 0.
  - W_STAT: on lane 0, wait for a 0 start bit within 8 cycles, else otimeout.
    - Sample the next 3 bits, then the end bit.
    - Token 010 with end bit 1: accepted.
    - Anything else: set ocrc_fail and go to DONE without waiting for busy.
  - W_BUSY: wait until lane 0 = 1 (card not busy).
    - Counter reaches BUSY_MAX first: set otimeout.
- DONE: odone = 1 for exactly one cycle, then IDLE.
  - ocrc_fail and otimeout are cleared on the next accepted istart, not in DONE.
- LANES = 1: only lane 0 is used and DEPTH = BLOCK_BYTES*8; there is no mode bit for 1-lane operation.

Test Plan:
- Read, LANES=4, card sends start, 1024 nibbles 0xF, per-lane CRC 0x7FA1, end bit -> 1024 owrite_en pulses (addr 0..1023, data 0xF), odone pulse, ocrc_fail=0, otimeout=0.
- Same read with one CRC bit flipped on lane 2 -> RAM written as before, odone pulse, ocrc_fail=1; next istart clears it.
- Read, lines held high for NAC_MAX cycles (NAC_MAX=100 in the bench) -> otimeout=1 and odone at cycle 101, no owrite_en.
- Write, RAM 0xF, card returns token 0 010 1 then busy for 50 cycles -> odata_oe high for 2+1+1024+16+1 cycles, each lane CRC 0x7FA1, odone after busy ends, no error.
- Write with token 101 -> ocrc_fail=1, odone without entering W_BUSY; busy held past BUSY_MAX in a separate run -> otimeout=1.
- LANES=1, BLOCK_BYTES=4, read of bytes 00 01 02 03 -> 32 writes in bit order, CRC check passes; irst pulsed low mid-R_DATA -> outputs at reset values, no odone.
